trace_readout_ctrl: RTL and testbench

- Sequences upload of a completed capture from the sample-packet RAM to the HUB register interface.
- On each trace-data read command it fetches the next two packets, oldest first, from the circular capture buffer.
- Fetched packets are packed into a 64-bit word that drives the eight 8-bit output registers.
- Sits between the capture engine (RAM write side plus completion handshake) and the HUB command decoder, and owns the RAM read port.

---
 rtl/trace_readout_ctrl.sv | 152 +++++++++++++++
 tb/tb_trace_readout_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_readout_ctrl.sv
`default_nettype none
// ============================================================================
// trace_readout_ctrl : uploads a completed capture from the packet RAM to the
//                      HUB registers two packets per read command, oldest first
// Revision 1.0 - initial release
// ============================================================================
module trace_readout_ctrl #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int ADDR_WIDTH          = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           capture_start,
  input  logic                           capture_done,
  input  logic [ADDR_WIDTH-1:0]          wr_ptr,
  input  logic [31:0]                    stored_count,
  input  logic                           read_req,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] mem_rd_data,
  output logic [63:0]                    out_data,
  output logic                           out_valid,
  output logic [1:0]                     out_count,
  output logic [31:0]                    remaining,
  output logic                           trace_ready,
  output logic                           busy,
  output logic                           rd_err
);

  localparam logic [32:0] DEPTH_W = 33'(2**ADDR_WIDTH);

  if (SAMPLE_PACKET_WIDTH != 32) begin : g_width_check
    $error("trace_readout_ctrl: SAMPLE_PACKET_WIDTH must be 32");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    RD0   = 3'd2,
    RD1   = 3'd3,
    LATCH = 3'd4
  } state_t;

  state_t                         state;
  logic [ADDR_WIDTH-1:0]          rd_ptr;
  logic [31:0]                    remaining_q;
  logic [SAMPLE_PACKET_WIDTH-1:0] lo_q;
  logic                           two_q;
  logic [63:0]                    data_q;
  logic [1:0]                     count_q;
  logic                           valid_q;
  logic                           trace_ready_q;
  logic                           rd_err_q;
  logic                           mem_rd_en_q;
  logic [ADDR_WIDTH-1:0]          mem_rd_addr_q;

  logic [31:0]                    n_cap;
  logic [1:0]                     cnt;
  logic [SAMPLE_PACKET_WIDTH-1:0] hi;
  logic                           latch_ok;

  assign n_cap = ({1'b0, stored_count} > DEPTH_W) ? DEPTH_W[31:0] : stored_count;
  assign cnt   = two_q ? 2'd2 : 2'd1;
  assign hi    = two_q ? mem_rd_data : '0;

  // The high packet only arrives during LATCH, so that cycle presents it
  // straight from the RAM; a simultaneous capture event or reset cancels it.
  assign latch_ok = (state == LATCH) && !capture_done && !capture_start && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      remaining_q   <= '0;
      lo_q          <= '0;
      two_q         <= 1'b0;
      data_q        <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      trace_ready_q <= 1'b0;
      rd_err_q      <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
    end else begin
      valid_q     <= 1'b0;
      rd_err_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      if (capture_done) begin
        rd_ptr        <= wr_ptr - n_cap[ADDR_WIDTH-1:0];
        remaining_q   <= n_cap;
        trace_ready_q <= 1'b1;
        state         <= READY;
      end else if (capture_start) begin
        remaining_q   <= '0;
        trace_ready_q <= 1'b0;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: rd_err_q <= read_req;
          READY: begin
            if (read_req) begin
              if (remaining_q == 32'd0) begin
                valid_q <= 1'b1;
                data_q  <= '0;
                count_q <= 2'd0;
              end else begin
                mem_rd_en_q   <= 1'b1;
                mem_rd_addr_q <= rd_ptr;
                state         <= RD0;
              end
            end
          end
          RD0: begin
            rd_err_q <= read_req;
            two_q    <= (remaining_q >= 32'd2);
            if (remaining_q >= 32'd2) begin
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= rd_ptr + ADDR_WIDTH'(1);
            end
            state <= RD1;
          end
          RD1: begin
            rd_err_q <= read_req;
            lo_q     <= mem_rd_data;
            state    <= LATCH;
          end
          LATCH: begin
            rd_err_q    <= read_req;
            data_q      <= {hi, lo_q};
            count_q     <= cnt;
            remaining_q <= remaining_q - 32'(cnt);
            rd_ptr      <= rd_ptr + ADDR_WIDTH'(cnt);
            state       <= READY;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign out_valid   = valid_q | latch_ok;
  assign out_data    = latch_ok ? {hi, lo_q} : data_q;
  assign out_count   = latch_ok ? cnt : count_q;
  assign remaining   = remaining_q;
  assign trace_ready = trace_ready_q;
  assign busy        = (state == RD0) || (state == RD1) || (state == LATCH);
  assign rd_err      = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_readout_ctrl.sv
`default_nettype none
// ============================================================================
// tb_trace_readout_ctrl : self-checking bench for trace_readout_ctrl
// Revision 1.0 - initial release
// ============================================================================
module tb_trace_readout_ctrl;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture_start;
  logic          capture_done;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   stored_count;
  logic          read_req;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;
  logic [63:0]   out_data;
  logic          out_valid;
  logic [1:0]    out_count;
  logic [31:0]   remaining;
  logic          trace_ready;
  logic          busy;
  logic          rd_err;

  trace_readout_ctrl #(.SAMPLE_PACKET_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .capture_start(capture_start),
    .capture_done(capture_done), .wr_ptr(wr_ptr), .stored_count(stored_count),
    .read_req(read_req), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_count(out_count), .remaining(remaining), .trace_ready(trace_ready),
    .busy(busy), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] aq[$];      // model: addresses of packets still to upload
  logic [AW-1:0] rd_log[$];  // addresses the DUT actually read
  int            tests  = 0;
  int            failed = 0;
  int            en_viol = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= ram[mem_rd_addr];
      rd_log.push_back(mem_rd_addr);
    end
  end

  always @(negedge clk) if (mem_rd_en && !busy) en_viol++;

  typedef struct {
    int wr;
    int sc;
    int exp_rem;
    int exp_first;
    int exp_cnt;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_data"}, out_data, 64'd0);
    chk({nm, "_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_cnt"}, 64'(out_count), 64'd0);
    chk({nm, "_rem"}, 64'(remaining), 64'd0);
    chk({nm, "_ready"}, 64'(trace_ready), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_err"}, 64'(rd_err), 64'd0);
    chk({nm, "_rden"}, 64'(mem_rd_en), 64'd0);
    chk({nm, "_addr"}, 64'(mem_rd_addr), 64'd0);
  endtask

  // Trace contents as a list of addresses, oldest first.
  task automatic model_capture(input int wr, input int sc);
    int n;
    n = (sc > DEPTH) ? DEPTH : sc;
    aq.delete();
    for (int i = 0; i < n; i++) aq.push_back(AW'((wr + 2 * DEPTH - n + i) % DEPTH));
  endtask

  task automatic do_capture(input int wr, input int sc);
    wr_ptr = AW'(wr);
    stored_count = 32'(sc);
    capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
    model_capture(wr, sc);
    chk("cap_rem", 64'(remaining), 64'(aq.size()));
    chk("cap_ready", 64'(trace_ready), 64'd1);
    chk("cap_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_read(input bit inject_err, output int got_cnt);
    int          exp_n;
    logic [31:0] lo, hi;
    exp_n = (aq.size() >= 2) ? 2 : aq.size();
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    if (exp_n == 0) begin
      chk("empty_valid", 64'(out_valid), 64'd1);
      chk("empty_data", out_data, 64'd0);
      chk("empty_cnt", 64'(out_count), 64'd0);
      chk("empty_rden", 64'(mem_rd_en), 64'd0);
      chk("empty_busy", 64'(busy), 64'd0);
      tick();
      chk("empty_pulse", 64'(out_valid), 64'd0);
      got_cnt = 0;
      return;
    end
    chk("rd0_en", 64'(mem_rd_en), 64'd1);
    chk("rd0_addr", 64'(mem_rd_addr), 64'(aq[0]));
    chk("rd0_busy", 64'(busy), 64'd1);
    chk("rd0_valid", 64'(out_valid), 64'd0);
    tick();
    chk("rd1_en", 64'(mem_rd_en), 64'(exp_n == 2));
    if (exp_n == 2) chk("rd1_addr", 64'(mem_rd_addr), 64'(aq[1]));
    chk("rd1_busy", 64'(busy), 64'd1);
    chk("rd1_valid", 64'(out_valid), 64'd0);
    if (inject_err) read_req = 1'b1;
    tick();
    read_req = 1'b0;
    if (inject_err) chk("busy_rd_err", 64'(rd_err), 64'd1);
    lo = ram[aq.pop_front()];
    hi = (exp_n == 2) ? ram[aq.pop_front()] : 32'd0;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", out_data, {hi, lo});
    chk("lat_cnt", 64'(out_count), 64'(exp_n));
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_rden", 64'(mem_rd_en), 64'd0);
    tick();
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_rem", 64'(remaining), 64'(aq.size()));
    chk("post_data", out_data, {hi, lo});
    got_cnt = exp_n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    int          c;
    logic [63:0] prev;

    tbl[0] = '{wr: 10,   sc: 5,    exp_rem: 5,    exp_first: 5,    exp_cnt: 2};
    tbl[1] = '{wr: 1,    sc: 3,    exp_rem: 3,    exp_first: 4094, exp_cnt: 2};
    tbl[2] = '{wr: 100,  sc: 5000, exp_rem: 4096, exp_first: 100,  exp_cnt: 2};
    tbl[3] = '{wr: 7,    sc: 1,    exp_rem: 1,    exp_first: 6,    exp_cnt: 1};
    tbl[4] = '{wr: 4095, sc: 4096, exp_rem: 4096, exp_first: 4095, exp_cnt: 2};
    tbl[5] = '{wr: 0,    sc: 0,    exp_rem: 0,    exp_first: 0,    exp_cnt: 0};
    tbl[6] = '{wr: 0,    sc: 4097, exp_rem: 4096, exp_first: 0,    exp_cnt: 2};

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    reset = 1'b1; capture_start = 1'b0; capture_done = 1'b0;
    wr_ptr = '0; stored_count = '0; read_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    // read before any capture
    read_req = 1'b1; tick(); read_req = 1'b0;
    chk("idle_rd_err", 64'(rd_err), 64'd1);
    chk("idle_valid", 64'(out_valid), 64'd0);
    tick();
    chk("idle_err_pulse", 64'(rd_err), 64'd0);

    // table-driven captures and first read
    for (int i = 0; i < 7; i++) begin
      do_capture(tbl[i].wr, tbl[i].sc);
      chk("tbl_rem", 64'(remaining), 64'(tbl[i].exp_rem));
      rd_log.delete();
      do_read(1'b0, c);
      chk("tbl_cnt", 64'(c), 64'(tbl[i].exp_cnt));
      if (tbl[i].exp_rem != 0) chk("tbl_first_addr", 64'(rd_log.size() > 0 ? rd_log[0] : AW'(0)), 64'(tbl[i].exp_first));
    end

    // basic read: 5 packets ending at 10
    do_capture(10, 5);
    rd_log.delete();
    do_read(1'b0, c); chk("basic_cnt0", 64'(c), 64'd2); chk("basic_rem0", 64'(remaining), 64'd3);
    do_read(1'b0, c); chk("basic_cnt1", 64'(c), 64'd2); chk("basic_rem1", 64'(remaining), 64'd1);
    do_read(1'b0, c); chk("basic_cnt2", 64'(c), 64'd1); chk("basic_rem2", 64'(remaining), 64'd0);
    chk("basic_hi_zero", 64'(out_data[63:32]), 64'd0);
    chk("basic_nreads", 64'(rd_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++) chk("basic_addr", 64'(rd_log[i]), 64'(5 + i));
    do_read(1'b0, c);
    chk("basic_empty_rem", 64'(remaining), 64'd0);

    // wrap-around
    do_capture(1, 3);
    rd_log.delete();
    do_read(1'b0, c);
    do_read(1'b0, c);
    chk("wrap_nreads", 64'(rd_log.size()), 64'd3);
    if (rd_log.size() == 3) begin
      chk("wrap_a0", 64'(rd_log[0]), 64'd4094);
      chk("wrap_a1", 64'(rd_log[1]), 64'd4095);
      chk("wrap_a2", 64'(rd_log[2]), 64'd0);
    end

    // read_req while busy is rejected, fetch continues
    do_capture(300, 6);
    do_read(1'b1, c);
    chk("busyerr_cnt", 64'(c), 64'd2);
    do_read(1'b0, c);

    // capture_done and capture_start together: done wins
    capture_start = 1'b1;
    do_capture(50, 3);
    capture_start = 1'b0;
    do_read(1'b0, c);

    // capture_start during RD1 abandons the fetch
    do_capture(20, 6);
    read_req = 1'b1; tick(); read_req = 1'b0;
    tick();
    capture_start = 1'b1; tick(); capture_start = 1'b0;
    aq.delete();
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_ready", 64'(trace_ready), 64'd0);
    chk("abort_rem", 64'(remaining), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    tick();
    chk("abort_valid2", 64'(out_valid), 64'd0);
    read_req = 1'b1; tick(); read_req = 1'b0;
    chk("abort_rd_err", 64'(rd_err), 64'd1);

    // capture_done during LATCH abandons the fetch, out_data unchanged
    do_capture(200, 4);
    do_read(1'b0, c);
    prev = out_data;
    read_req = 1'b1; tick(); read_req = 1'b0;
    tick(); tick();
    wr_ptr = AW'(300); stored_count = 32'd2; capture_done = 1'b1;
    #1;
    chk("latabort_valid", 64'(out_valid), 64'd0);
    chk("latabort_data", out_data, prev);
    tick();
    capture_done = 1'b0;
    model_capture(300, 2);
    chk("latabort_valid2", 64'(out_valid), 64'd0);
    chk("latabort_data2", out_data, prev);
    chk("latabort_rem", 64'(remaining), 64'd2);
    chk("latabort_ready", 64'(trace_ready), 64'd1);
    do_read(1'b0, c);

    // randomized traces against the model
    for (int it = 0; it < 30; it++) begin
      int wr, sc, nr;
      wr = $urandom_range(0, DEPTH - 1);
      sc = ($urandom_range(0, 7) == 0) ? $urandom_range(4000, 6000) : $urandom_range(0, 9);
      do_capture(wr, sc);
      nr = $urandom_range(1, 6);
      for (int r = 0; r < nr; r++) do_read(1'($urandom_range(0, 3) == 0), c);
    end

    // reset in LATCH
    do_capture(77, 8);
    read_req = 1'b1; tick(); read_req = 1'b0;
    tick(); tick();
    chk("rst_in_latch", 64'(busy), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    aq.delete();
    chk_reset_vals("midrst");

    chk("rd_en_only_busy", 64'(en_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
